ps2_key_fifo: RTL
=================

Name: ps2_key_fifo

Overview:
Parametrised PS/2 keyboard front end. It receives PS/2 device frames entirely in the clk domain (no derived clocks) and validates start, parity and stop bits. It folds E0/F0 prefixes into a single make/break event and buffers events in a FWFT FIFO. The CPU-facing MMIO read path pops the FIFO with ren, so keystrokes are no longer lost between reads.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
DEBOUNCE_MAX, 19, clk cycles an input must be stable before the filtered value updates.
TIMEOUT_CYCLES, 50000, clk cycles without a filtered kclk falling edge before a partial frame is aborted.
CNT_W, $clog2(FIFO_DEPTH)+1, width of the count output.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
ps2_clk  in  1  raw PS/2 clock pin (async).
ps2_data  in  1  raw PS/2 data pin (async).
ren  in  1  pop the head event; ignored when empty.
data  out  16  head event; 0 when empty.
ready  out  1  FIFO not empty.
count  out  CNT_W  events held.
overflow  out  1  sticky; an event was dropped because the FIFO was full.
frame_err  out  1  one-cycle pulse on any rejected frame.

Behaviour:
- Reset (async, rst=1): FSM IDLE, prefix flags cleared, FIFO empty, data=0, ready=0, count=0, overflow=0, frame_err=0, filtered kclk/kdata=1, debounce counters=0.
- Input conditioning: 2-flop synchroniser per pin, then debounce. The filtered output takes the synced value after it has been stable for DEBOUNCE_MAX+1 cycles. Falling edge = filtered kclk 1->0, registered as a one-cycle strobe.
- Frame FSM (advances only on the strobe, sampling filtered kdata):
  - IDLE: data=0 (start bit) -> DATA with bit index 0; data=1 -> stay in IDLE, no error.
  - DATA: shift LSB first; after bit 7 -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: data=1 and parity ok -> byte valid (1-cycle) -> IDLE. Otherwise frame_err pulse and byte discarded -> IDLE.
- Timeout: in any state other than IDLE, a counter counts cycles since the last strobe. At TIMEOUT_CYCLES: frame_err pulse, FSM -> IDLE, partial byte discarded, prefix flags preserved.
- Prefix decode on each valid byte:
  - 0xE0 -> ext=1.
  - 0xF0 -> brk=1.
  - Any other byte -> push {brk, ext, 6'b0, byte}, then clear ext and brk in the same cycle.
  - E1 and all other bytes are pushed as ordinary events.
  - A frame error does not clear flags.
- FIFO:
  - First-word fall-through: data reflects the head combinationally from registered storage, with 0-latency visibility the cycle after the push.
  - Push latency: last kclk strobe -> event visible on data within 2 clk.
  - Pop on ren && ready; the next entry appears the following cycle.
  - Push while full without pop: event dropped, overflow set.
  - Simultaneous push+pop when full: both succeed, count unchanged, no overflow.
  - Simultaneous push+pop when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH and count saturates at FIFO_DEPTH.
- overflow clears only on a ren pop that leaves the FIFO empty, or on rst.

Optional Feature:
PS2_PARITY_CHECK_EN: when defined, odd parity over the 8 data bits plus the parity bit is required; a mismatch gives frame_err and the byte is dropped. When undefined, the parity bit is sampled but ignored, and only start/stop/timeout are checked.

Decomposition:
- Package ps2_pkg: PS2_EXT=8'hE0, PS2_BRK=8'hF0, event bit indices (EV_BRK=15, EV_EXT=14, EV_CODE=7:0), FSM state enum {IDLE, DATA, PARITY, STOP}.
- One sub-module, ps2_frame_rx: synchronisers, debouncers, strobe, FSM, timeout. It outputs byte[7:0], byte_valid and frame_err.
- Prefix logic and FIFO stay in ps2_key_fifo.

Test Plan:
- Frame 0x1C with good parity -> data=0x001C, ready=1, count=1; ren -> data=0, ready=0.
- Bytes F0,1C -> single event 0x801C. Bytes E0,75 -> 0x4075. Bytes E0,F0,75 -> 0xC075, count=1.
- 9 make codes 0x15..0x1D, no reads (DEPTH=8) -> count=8, overflow=1, head 0x0015. Pop all 8 -> last data 0x001C, overflow=0.
- Full FIFO, ren asserted in the same cycle a 0x2A push completes -> count stays 8, overflow=0, tail entry 0x002A.
- 0x1C with the parity bit flipped -> frame_err pulse, count=0 (with PS2_PARITY_CHECK_EN); event 0x001C pushed without it. Stop bit=0 -> frame_err in both builds.
- Start + 5 bits then idle TIMEOUT_CYCLES -> frame_err, FSM IDLE. Following clean 0x1C -> 0x001C. Assert rst mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, event layout and frame-receiver state encoding for the PS/2 key path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int EV_BRK     = 15;
    localparam int EV_EXT     = 14;
    localparam int EV_CODE_HI = 7;
    localparam int EV_CODE_LO = 0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic logic [15:0] make_event(input logic brk, input logic ext,
                                               input logic [7:0] code);
        logic [15:0] ev;
        ev                        = '0;
        ev[EV_BRK]                = brk;
        ev[EV_EXT]                = ext;
        ev[EV_CODE_HI:EV_CODE_LO] = code;
        return ev;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: sync + debounce both pins, falling-edge strobe, 11-bit frame FSM, timeout.
// Latency: rx_byte_vld one clk after the stop-bit strobe; strobe lags the pins by 2 + DEBOUNCE_MAX+1 clk.
// Backpressure: none; the device cannot be stalled, so rx_byte_vld is a single-cycle pulse.
// Build option PS2_PARITY_CHECK_EN enables odd-parity rejection.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int DEBOUNCE_MAX   = 19,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int DB_W = (DEBOUNCE_MAX < 1) ? 1 : $clog2(DEBOUNCE_MAX + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Index 0 is the PS/2 clock pin, index 1 the data pin.
    logic [1:0]           sync_1, sync_2, filt;
    logic [1:0][DB_W-1:0] db_cnt;
    logic                 fall_stb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1   <= '1;
            sync_2   <= '1;
            filt     <= '1;
            db_cnt   <= '0;
            fall_stb <= 1'b0;
        end else begin
            sync_1   <= {ps2_data, ps2_clk};
            sync_2   <= sync_1;
            fall_stb <= filt[0] && !sync_2[0] && (db_cnt[0] == DB_W'(DEBOUNCE_MAX));
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_MAX)) begin
                    filt[i]   <= sync_2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    rx_state_t       state, state_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            par_bit, par_bit_n;
    logic [TO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic            valid_n, err_n;
    logic            par_ok;

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{shreg, par_bit};
`else
    // Parity is still captured so the frame shape is identical; its value is not enforced.
    assign par_ok = (^{shreg, par_bit}) | 1'b1;
`endif

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        tmo_cnt_n = '0;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        if (fall_stb) begin
            unique case (state)
                IDLE: begin
                    if (!filt[1]) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end
                DATA: begin
                    shreg_n   = {filt[1], shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_bit_n = filt[1];
                    state_n   = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (filt[1] && par_ok) valid_n = 1'b1;
                    else                   err_n   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                err_n   = 1'b1;
                state_n = IDLE;
            end else begin
                tmo_cnt_n = tmo_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            par_bit    <= par_bit_n;
            tmo_cnt    <= tmo_cnt_n;
            byte_valid <= valid_n;
            frame_err  <= err_n;
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard front end: frame receive, E0/F0 prefix folding, FWFT event FIFO popped by ren.
// Latency: event visible on data 2 clk after the final kclk strobe; pop takes effect next clk.
// Backpressure: none toward the keyboard; a full FIFO drops the event and sets sticky overflow.
// Build option PS2_PARITY_CHECK_EN (in ps2_frame_rx) enables odd-parity rejection.
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int DEBOUNCE_MAX   = 19,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             ren,
    output logic [15:0]      data,
    output logic             ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       byte_valid;

    ps2_frame_rx #(
        .DEBOUNCE_MAX   (DEBOUNCE_MAX),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    logic        ext, brk;
    logic        is_prefix, push;
    logic [15:0] ev;

    assign is_prefix = (rx_byte == PS2_EXT) || (rx_byte == PS2_BRK);
    assign push      = byte_valid && !is_prefix;
    assign ev        = make_event(brk, ext, rx_byte);

    // Frame errors never touch the flags; only a completed non-prefix byte consumes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    logic [15:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full, pop, push_ok;

    assign full    = (cnt == CNT_W'(FIFO_DEPTH));
    assign pop     = ren && (cnt != '0);
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= ev;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop);
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (pop && !push_ok && (cnt == CNT_W'(1)))
                overflow <= 1'b0;
        end
    end

    assign ready = (cnt != '0);
    assign count = cnt;
    assign data  = ready ? mem[rd_ptr] : 16'h0000;

endmodule
